vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator and pixel output stage; successor to the fixed 640x480 core.
//  Generates hsync/vsync/DE from programmable porches, polarities and pixel-clock division.
//  Issues fetch coordinates ahead of the beam and re-aligns sync/DE to a pixel source with FETCH_LAT latency.
//  Sits between the clock/PLL block and the demo pixel generators; drives the board's R/G/B DAC pins.
// PARAMETERS
//  H_VIS       640  visible pixels per line
//  H_FP        16   horizontal front porch (pixels)
//  H_SYNC      96   horizontal sync width (pixels)
//  H_BP        48   horizontal back porch (pixels)
//  V_VIS       480  visible lines per frame
//  V_FP        10   vertical front porch (lines)
//  V_SYNC      2    vertical sync width (lines)
//  V_BP        33   vertical back porch (lines)
//  HSYNC_POL   0    active level of h_sync (0 = active-low)
//  VSYNC_POL   0    active level of v_sync (0 = active-low)
//  COLOR_BITS  4    bits per colour channel
//  FETCH_LAT   1    pixel ticks from hpos/vpos to matching pixstream (0..7)
//  PIX_DIV     1    clk cycles per pixel tick (1..8)
// PORTS
//  clk_25_175      in   1             system/pixel clock
//  reset           in   1             asynchronous, active-high reset
//  pixstream       in   3*COLOR_BITS  {b,g,r} for fetch coord issued FETCH_LAT ticks earlier
//  hpos            out  12            fetch x (counter value, 0..H_TOTAL-1)
//  vpos            out  12            fetch y (counter value, 0..V_TOTAL-1)
//  fetch_valid     out  1             hpos<H_VIS && vpos<V_VIS
//  r, g, b         out  COLOR_BITS    registered colour, forced 0 outside DE
//  h_sync, v_sync  out  1             sync, aligned with r/g/b
//  drawing_pixels  out  1             DE, aligned with r/g/b
//  line_start      out  1             1-clk pulse, aligned DE path, at hcnt==0
//  frame_start     out  1             1-clk pulse, aligned DE path, at hcnt==0 && vcnt==0
// BEHAVIOUR
//  - H_TOTAL=H_VIS+H_FP+H_SYNC+H_BP (800 default); V_TOTAL likewise (525).
//  - Horizontal regions by hcnt: visible [0,H_VIS), FP, sync [H_VIS+H_FP, +H_SYNC), BP. Vertical same on vcnt.
//  - Pixel tick: 1-clk strobe every PIX_DIV clks from a divider (0..PIX_DIV-1). All counters/pipeline advance only on tick.
//  - On tick: hcnt==H_TOTAL-1 -> hcnt=0, vcnt+1; if also vcnt==V_TOTAL-1 -> vcnt=0. Otherwise hcnt+1.
//  - hpos/vpos = hcnt/vcnt directly (combinational from counter regs).
//  - Align pipe: {DE,hs,vs,ls,fs} shift through FETCH_LAT stages on tick. Final output regs load on tick:
//    r/g/b=DE?pixstream:0, syncs=region^~POL (i.e. active level when in sync region).
//  - Total latency hpos -> pins = FETCH_LAT+1 ticks; pixstream sampled on the tick FETCH_LAT ticks after issue.
//  - line_start/frame_start high for exactly one clk (the clk after the loading tick), even when PIX_DIV>1.
//  - Reset (async assert, sync release): divider=0, hcnt=vcnt=0, pipe=inactive (DE=0, syncs inactive level),
//    r=g=b=0, drawing_pixels=0, pulses=0. First tick is the first clk after reset deasserts.
//  - Reset mid-frame: all state returns to reset values immediately; no partial sync pulse held.
//  - Counters 12 bits; elaboration error if H_TOTAL or V_TOTAL > 4096, PIX_DIV or FETCH_LAT out of range.
//  - pixstream ignored (not sampled into r/g/b) when aligned DE=0.
// TESTING
//  - Defaults, 2 frames: frame_start spacing 420000 clks; line_start spacing 800; h_sync low 96 clks/line;
//    v_sync low 2 lines (1600 clks); DE high 640 clks/line x 480 lines.
//  - Latency: model pixstream = hpos[11:0] delayed 1 tick; r/g/b at first DE clk = 0x000, at 640th = {3'h27F bits};
//    DE rising edge exactly 2 ticks after hpos wraps to 0 on line 0.
//  - FETCH_LAT=3: DE/syncs shift by 2 extra ticks vs FETCH_LAT=1; colour still matches hpos of issue.
//  - PIX_DIV=2: every output holds 2 clks; frame_start spacing 840000 clks; pulses still 1 clk wide.
//  - HSYNC_POL=1,VSYNC_POL=1, 800x600 timing (40/128/88, 1/4/23): h_sync high 128 ticks, frame 1056x628.
//  - Assert reset at line 300, pixel 700 for 3 clks: all outputs reach reset values without clk edge;
//    after release, frame_start after FETCH_LAT+1 ticks, timing otherwise identical to cold start.

Source files
------------

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator and pixel output stage.
//
// A pixel-tick divider paces a horizontal/vertical raster counter pair. The
// counters are published as fetch coordinates (hpos/vpos) ahead of the beam.
// Per-pixel attributes (DE, sync regions, line/frame start) travel through a
// FETCH_LAT-deep alignment pipe. They then meet the pixel source's reply in
// the final output registers.
//
// Ports
//   clk_25_175      in   1             system / pixel clock
//   reset           in   1             asynchronous, active-high reset
//   pixstream       in   3*COLOR_BITS  {b,g,r} for the coordinate issued
//                                      FETCH_LAT ticks earlier
//   hpos, vpos      out  12            fetch coordinate (raw counter values)
//   fetch_valid     out  1             fetch coordinate is inside the visible area
//   r, g, b         out  COLOR_BITS    registered colour, zero outside DE
//   h_sync, v_sync  out  1             syncs, aligned with r/g/b
//   drawing_pixels  out  1             display enable, aligned with r/g/b
//   line_start      out  1             one-clk pulse when the aligned pixel has hcnt==0
//   frame_start     out  1             one-clk pulse when the aligned pixel has hcnt==0, vcnt==0
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int COLOR_BITS = 4,
    parameter int FETCH_LAT  = 1,
    parameter int PIX_DIV    = 1
) (
    input  logic                      clk_25_175,
    input  logic                      reset,
    input  logic [3*COLOR_BITS-1:0]   pixstream,
    output logic [11:0]               hpos,
    output logic [11:0]               vpos,
    output logic                      fetch_valid,
    output logic [COLOR_BITS-1:0]     r,
    output logic [COLOR_BITS-1:0]     g,
    output logic [COLOR_BITS-1:0]     b,
    output logic                      h_sync,
    output logic                      v_sync,
    output logic                      drawing_pixels,
    output logic                      line_start,
    output logic                      frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Reject configurations the 12-bit counters and 3-bit divider cannot express.
    if (H_TOTAL > 4096) begin : g_err_h_total
        $error("vga_timing_gen: H_TOTAL exceeds 4096");
    end
    if (V_TOTAL > 4096) begin : g_err_v_total
        $error("vga_timing_gen: V_TOTAL exceeds 4096");
    end
    if ((PIX_DIV < 1) || (PIX_DIV > 8)) begin : g_err_pix_div
        $error("vga_timing_gen: PIX_DIV must be 1..8");
    end
    if ((FETCH_LAT < 0) || (FETCH_LAT > 7)) begin : g_err_fetch_lat
        $error("vga_timing_gen: FETCH_LAT must be 0..7");
    end
    if ((H_SYNC < 1) || (V_SYNC < 1)) begin : g_err_sync_width
        $error("vga_timing_gen: sync widths must be at least 1");
    end

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS_W    = 12'(H_VIS);
    localparam logic [11:0] V_VIS_W    = 12'(V_VIS);
    localparam logic [11:0] HS_FIRST   = 12'(H_VIS + H_FP);
    localparam logic [11:0] HS_LAST    = 12'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_FIRST   = 12'(V_VIS + V_FP);
    localparam logic [11:0] VS_LAST    = 12'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [2:0]  DIV_LAST   = 3'(PIX_DIV - 1);
    localparam logic        HS_ACT     = 1'(HSYNC_POL);
    localparam logic        VS_ACT     = 1'(VSYNC_POL);
    // A zero-latency build still declares one (unused) stage so the array is legal.
    localparam int          PIPE_N     = (FETCH_LAT == 0) ? 1 : FETCH_LAT;
    localparam int          CW         = 3 * COLOR_BITS;

    // Attribute vector bit positions.
    localparam int A_DE = 4;
    localparam int A_HS = 3;
    localparam int A_VS = 2;
    localparam int A_LS = 1;
    localparam int A_FS = 0;

    logic [2:0]    div_q;
    logic [2:0]    div_d;
    logic          tick_s;
    logic [11:0]   hcnt_q;
    logic [11:0]   hcnt_d;
    logic [11:0]   vcnt_q;
    logic [11:0]   vcnt_d;
    logic [4:0]    attr_s;
    logic [4:0]    pipe_q [PIPE_N];
    logic [4:0]    aligned_s;
    logic [CW-1:0] color_q;
    logic [CW-1:0] color_d;
    logic          hs_q;
    logic          hs_d;
    logic          vs_q;
    logic          vs_d;
    logic          de_q;
    logic          ls_q;
    logic          fs_q;

    // The tick fires while the divider sits at 0, so the first clk after reset is a tick.
    assign tick_s = (div_q == 3'd0);

    // Next-state for the pixel divider and the raster counters.
    always_comb begin
        div_d  = div_q;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (div_q == DIV_LAST) begin
            div_d = 3'd0;
        end else begin
            div_d = div_q + 3'd1;
        end
        if (tick_s) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = 12'd0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d = 12'd0;
                end else begin
                    vcnt_d = vcnt_q + 12'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 12'd1;
            end
        end else begin
            hcnt_d = hcnt_q;
            vcnt_d = vcnt_q;
        end
    end

    // Divider and raster counter registers.
    always_ff @(posedge clk_25_175 or posedge reset) begin
        if (reset) begin
            div_q  <= 3'd0;
            hcnt_q <= 12'd0;
            vcnt_q <= 12'd0;
        end else begin
            div_q  <= div_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Attributes of the coordinate currently being fetched. Sync bits mean
    // "inside the sync region"; polarity is applied only at the pins.
    always_comb begin
        attr_s       = 5'd0;
        attr_s[A_DE] = (hcnt_q < H_VIS_W) && (vcnt_q < V_VIS_W);
        attr_s[A_HS] = (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST);
        attr_s[A_VS] = (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST);
        attr_s[A_LS] = (hcnt_q == 12'd0);
        attr_s[A_FS] = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
    end

    assign hpos        = hcnt_q;
    assign vpos        = vcnt_q;
    assign fetch_valid = attr_s[A_DE];

    // Alignment pipe: delays the attributes by FETCH_LAT ticks to match pixstream.
    always_ff @(posedge clk_25_175 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_N; i++) begin
                pipe_q[i] <= 5'd0;
            end
        end else if (tick_s) begin
            pipe_q[0] <= attr_s;
            for (int i = 1; i < PIPE_N; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign aligned_s = (FETCH_LAT == 0) ? attr_s : pipe_q[PIPE_N-1];

    // Output-stage next values; pixstream is ignored outside DE.
    always_comb begin
        color_d = {CW{1'b0}};
        hs_d    = ~HS_ACT;
        vs_d    = ~VS_ACT;
        if (aligned_s[A_DE]) begin
            color_d = pixstream;
        end else begin
            color_d = {CW{1'b0}};
        end
        if (aligned_s[A_HS]) begin
            hs_d = HS_ACT;
        end else begin
            hs_d = ~HS_ACT;
        end
        if (aligned_s[A_VS]) begin
            vs_d = VS_ACT;
        end else begin
            vs_d = ~VS_ACT;
        end
    end

    // Pin registers. Levels update on ticks; the start pulses are qualified by
    // the tick so they last one clk even when a pixel spans several clks.
    always_ff @(posedge clk_25_175 or posedge reset) begin
        if (reset) begin
            color_q <= {CW{1'b0}};
            hs_q    <= ~HS_ACT;
            vs_q    <= ~VS_ACT;
            de_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            ls_q <= tick_s & aligned_s[A_LS];
            fs_q <= tick_s & aligned_s[A_FS];
            if (tick_s) begin
                color_q <= color_d;
                hs_q    <= hs_d;
                vs_q    <= vs_d;
                de_q    <= aligned_s[A_DE];
            end
        end
    end

    assign r              = color_q[COLOR_BITS-1:0];
    assign g              = color_q[2*COLOR_BITS-1:COLOR_BITS];
    assign b              = color_q[3*COLOR_BITS-1:2*COLOR_BITS];
    assign h_sync         = hs_q;
    assign v_sync         = vs_q;
    assign drawing_pixels = de_q;
    assign line_start     = ls_q;
    assign frame_start    = fs_q;

endmodule
